// File: rtl/mem_byte_writer.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_writer
// Description : Serialises one store request (address, 32-bit data, size)
//               onto a byte-wide memory write port, MSB-first at ascending
//               addresses, so that a word written here reads back unchanged
//               through the instruction fetcher. HOLD idle cycles may be
//               inserted after every byte strobe for slow memories.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               req_valid/req_ready      - request handshake
//               req_addr/req_data/req_size - store address, data, size
//                                          (0=byte 1=half 2=word 3=illegal)
//               busy, done, err          - status; done/err are 1-cycle pulses
//               mem_a/mem_dout/mem_wr    - byte-wide memory write port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_writer #(
    parameter int ADDR_W = 32,
    parameter int HOLD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    output logic              mem_wr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam bit              c_HAS_GAP  = (HOLD > 0);
    localparam logic [3:0]      c_GAP_INIT = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;
    localparam logic [ADDR_W-1:0] c_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [31:0]         r_shreg;   // bytes still to write, next one in [31:24]
    logic [ADDR_W-1:0]   r_ptr;     // address of the next byte to write
    logic [1:0]          r_cnt;     // bytes still to write after the current one
    logic [3:0]          r_gcnt;    // gap cycles remaining after this one

    logic [31:0]         w_aligned;
    logic [1:0]          w_cnt_init;

    // Left-align the stored bytes so the first one to go out sits in [31:24].
    // The first byte is emitted at accept, so the count starts at N-1.
    always_comb begin
        w_aligned  = req_data;
        w_cnt_init = 2'd3;
        case (req_size)
            2'd0: begin
                w_aligned  = {req_data[7:0], 24'd0};
                w_cnt_init = 2'd0;
            end
            2'd1: begin
                w_aligned  = {req_data[15:0], 16'd0};
                w_cnt_init = 2'd1;
            end
            default: begin
                w_aligned  = req_data;
                w_cnt_init = 2'd3;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shreg   <= 32'd0;
            r_ptr     <= '0;
            r_cnt     <= 2'd0;
            r_gcnt    <= 4'd0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= 8'd0;
            mem_wr    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                // FIN keeps req_ready high, so it accepts exactly like IDLE.
                IDLE, FIN: begin
                    r_state   <= IDLE;
                    mem_wr    <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (req_valid) begin
                        if (req_size == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            // First strobe is presented in the cycle after accept.
                            r_state   <= WRITE;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                            mem_wr    <= 1'b1;
                            mem_a     <= req_addr;
                            mem_dout  <= w_aligned[31:24];
                            r_shreg   <= {w_aligned[23:0], 8'd0};
                            r_ptr     <= req_addr + c_ONE;
                            r_cnt     <= w_cnt_init;
                        end
                    end
                end
                WRITE: begin
                    if (c_HAS_GAP) begin
                        r_state <= GAP;
                        mem_wr  <= 1'b0;
                        r_gcnt  <= c_GAP_INIT;
                    end else if (r_cnt != 2'd0) begin
                        mem_wr   <= 1'b1;
                        mem_a    <= r_ptr;
                        mem_dout <= r_shreg[31:24];
                        r_shreg  <= {r_shreg[23:0], 8'd0};
                        r_ptr    <= r_ptr + c_ONE;
                        r_cnt    <= r_cnt - 2'd1;
                    end else begin
                        r_state   <= FIN;
                        mem_wr    <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                GAP: begin
                    if (r_gcnt != 4'd0) begin
                        r_gcnt <= r_gcnt - 4'd1;
                    end else if (r_cnt != 2'd0) begin
                        r_state  <= WRITE;
                        mem_wr   <= 1'b1;
                        mem_a    <= r_ptr;
                        mem_dout <= r_shreg[31:24];
                        r_shreg  <= {r_shreg[23:0], 8'd0};
                        r_ptr    <= r_ptr + c_ONE;
                        r_cnt    <= r_cnt - 2'd1;
                    end else begin
                        r_state   <= FIN;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_byte_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_byte_writer
// Description : Self-checking bench for mem_byte_writer. Expected memory
//               writes and done/err pulses are queued when a request is
//               issued; a negedge monitor pops and compares them as the DUT
//               presents them. A second instance with HOLD=2 checks gap timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_byte_writer;

    typedef struct {
        int          kind;   // 0 = write, 1 = done, 2 = err
        logic [31:0] a;
        logic [7:0]  d;
    } evt_t;

    logic        clk;
    logic        rst;

    // HOLD=0 instance
    logic        req_valid, req_ready, busy, done, err, mem_wr;
    logic [31:0] req_addr, req_data, mem_a;
    logic [1:0]  req_size;
    logic [7:0]  mem_dout;

    // HOLD=2 instance
    logic        req_valid2, req_ready2, busy2, done2, err2, mem_wr2;
    logic [31:0] req_addr2, req_data2, mem_a2;
    logic [1:0]  req_size2;
    logic [7:0]  mem_dout2;

    int   tests = 0;
    int   fails = 0;
    evt_t sb[$];

    mem_byte_writer #(.ADDR_W(32), .HOLD(0)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .busy(busy), .done(done), .err(err),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr)
    );

    mem_byte_writer #(.ADDR_W(32), .HOLD(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_addr(req_addr2), .req_data(req_data2), .req_size(req_size2),
        .busy(busy2), .done(done2), .err(err2),
        .mem_a(mem_a2), .mem_dout(mem_dout2), .mem_wr(mem_wr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input int kind, input logic [31:0] a, input logic [7:0] d);
        evt_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got event kind %0d (a=0x%0h d=0x%0h), expected none", kind, a, d);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", 32'(kind), 32'(e.kind));
            if (kind == 0 && e.kind == 0) begin
                chk("sb_addr", a, e.a);
                chk("sb_data", {24'd0, d}, {24'd0, e.d});
            end
        end
    endtask

    // Monitor for the HOLD=0 instance
    always @(negedge clk) begin
        if (mem_wr) pop_chk(0, mem_a, mem_dout);
        if (done)   pop_chk(1, 32'd0, 8'd0);
        if (err)    pop_chk(2, 32'd0, 8'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected events for one store: N bytes MSB-first from the low N data bytes.
    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int   n;
        evt_t e;
        if (s == 2'd3) begin
            e.kind = 2; e.a = 32'd0; e.d = 8'd0;
            sb.push_back(e);
        end else begin
            n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
            for (int i = 0; i < n; i++) begin
                e.kind = 0;
                e.a    = a + 32'(i);
                e.d    = d[8*(n-1-i) +: 8];
                sb.push_back(e);
            end
            e.kind = 1; e.a = 32'd0; e.d = 8'd0;
            sb.push_back(e);
        end
    endtask

    task automatic run_req(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input int exp_lat);
        int lat;
        push_store(a, d, s);
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!(done || err) && lat < 50) begin
            tick();
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_ready_at_end"}, {31'd0, req_ready}, 32'd1);
        chk({nm, "_busy_at_end"}, {31'd0, busy}, 32'd0);
        tick();
    endtask

    initial begin
        logic [15:0] wrm;
        logic [15:0] dnm;
        int          lat;

        rst = 1'b1;
        req_valid = 1'b0; req_addr = 32'd0; req_data = 32'd0; req_size = 2'd0;
        req_valid2 = 1'b0; req_addr2 = 32'd0; req_data2 = 32'd0; req_size2 = 2'd0;
        tick();
        tick();

        // Reset state
        chk("rst_ready",  {31'd0, req_ready}, 32'd1);
        chk("rst_busy",   {31'd0, busy},      32'd0);
        chk("rst_done",   {31'd0, done},      32'd0);
        chk("rst_err",    {31'd0, err},       32'd0);
        chk("rst_wr",     {31'd0, mem_wr},    32'd0);
        chk("rst_a",      mem_a,              32'd0);
        chk("rst_dout",   {24'd0, mem_dout},  32'd0);
        chk("rst_ready2", {31'd0, req_ready2}, 32'd1);
        chk("rst_wr2",    {31'd0, mem_wr2},   32'd0);
        rst = 1'b0;
        tick();

        // 1: word 0xDEADBEEF at 0x100, cycle-by-cycle
        push_store(32'h100, 32'hDEADBEEF, 2'd2);
        req_addr = 32'h100; req_data = 32'hDEADBEEF; req_size = 2'd2; req_valid = 1'b1;
        tick();                                  // cycle 1
        req_valid = 1'b0;
        chk("t1_c1_ready", {31'd0, req_ready}, 32'd0);
        chk("t1_c1_busy",  {31'd0, busy},      32'd1);
        chk("t1_c1_a",     mem_a,              32'h100);
        chk("t1_c1_dout",  {24'd0, mem_dout},  32'hDE);
        tick();                                  // cycle 2
        chk("t1_c2_dout",  {24'd0, mem_dout},  32'hAD);
        tick();                                  // cycle 3
        chk("t1_c3_a",     mem_a,              32'h102);
        tick();                                  // cycle 4
        chk("t1_c4_dout",  {24'd0, mem_dout},  32'hEF);
        chk("t1_c4_wr",    {31'd0, mem_wr},    32'd1);
        tick();                                  // cycle 5
        chk("t1_c5_done",  {31'd0, done},      32'd1);
        chk("t1_c5_ready", {31'd0, req_ready}, 32'd1);
        chk("t1_c5_wr",    {31'd0, mem_wr},    32'd0);
        tick();                                  // cycle 6
        chk("t1_c6_done",  {31'd0, done},      32'd0);
        chk("t1_c6_wr",    {31'd0, mem_wr},    32'd0);
        chk("t1_c6_hold_a", mem_a,             32'h103);

        // 2: byte at 0x20
        run_req("t2_byte", 32'h20, 32'h123456AB, 2'd0, 2);
        // 3: half wrapping the address space
        run_req("t3_half_wrap", 32'hFFFFFFFF, 32'h0000CAFE, 2'd1, 3);
        // 4: illegal size
        run_req("t4_illegal", 32'h40, 32'h11111111, 2'd3, 1);
        chk("t4_no_done", {31'd0, done}, 32'd0);

        // 5a: back-to-back, second request held from cycle 1
        push_store(32'h500, 32'hA1B2C3D4, 2'd2);
        push_store(32'h600, 32'h0F1E2D3C, 2'd2);
        req_addr = 32'h500; req_data = 32'hA1B2C3D4; req_size = 2'd2; req_valid = 1'b1;
        tick();                                  // cycle 1
        req_addr = 32'h600; req_data = 32'h0F1E2D3C;
        tick(); tick(); tick();                  // cycle 4
        chk("t5_blocked_ready", {31'd0, req_ready}, 32'd0);
        tick();                                  // cycle 5 (FIN)
        chk("t5_fin_done",  {31'd0, done},      32'd1);
        chk("t5_fin_ready", {31'd0, req_ready}, 32'd1);
        tick();                                  // cycle 6
        req_valid = 1'b0;
        chk("t5_b2b_wr", {31'd0, mem_wr}, 32'd1);
        chk("t5_b2b_a",  mem_a,           32'h600);
        lat = 1;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        chk("t5_b2b_latency", 32'(lat), 32'd5);
        tick();

        // 5b: HOLD=2 word, strobes at 1,4,7,10, done at 13
        wrm = 16'd0;
        dnm = 16'd0;
        req_addr2 = 32'h200; req_data2 = 32'h01020304; req_size2 = 2'd2; req_valid2 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            req_valid2 = 1'b0;
            if (mem_wr2) wrm[c] = 1'b1;
            if (done2)   dnm[c] = 1'b1;
            if (c == 1 || c == 4 || c == 7 || c == 10) begin
                chk("t5h_addr", mem_a2, 32'h200 + 32'((c - 1) / 3));
                chk("t5h_data", {24'd0, mem_dout2}, 32'((c - 1) / 3 + 1));
            end
            if (c == 2) begin
                chk("t5h_gap_hold_a", mem_a2, 32'h200);
                chk("t5h_gap_hold_d", {24'd0, mem_dout2}, 32'h01);
                chk("t5h_gap_busy", {31'd0, busy2}, 32'd1);
            end
        end
        chk("t5h_wr_mask",   {16'd0, wrm}, 32'h0492);
        chk("t5h_done_mask", {16'd0, dnm}, 32'h2000);

        // 6: reset after the second strobe of a word
        push_store(32'h300, 32'h11223344, 2'd2);
        req_addr = 32'h300; req_data = 32'h11223344; req_size = 2'd2; req_valid = 1'b1;
        tick();                                  // cycle 1
        req_valid = 1'b0;
        tick();                                  // cycle 2
        rst = 1'b1;
        tick();                                  // cycle 3
        rst = 1'b0;
        chk("t6_wr",    {31'd0, mem_wr},    32'd0);
        chk("t6_busy",  {31'd0, busy},      32'd0);
        chk("t6_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_done",  {31'd0, done},      32'd0);
        chk("t6_pending_after_abort", 32'(sb.size()), 32'd3);
        sb.delete();
        tick(); tick(); tick();
        chk("t6_no_late_done", {31'd0, done}, 32'd0);
        run_req("t6_after_reset", 32'h400, 32'h00000055, 2'd0, 2);

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
